booth_mac_accumulator: RTL and testbench

BOOTH_MAC_ACCUMULATOR -- requirements
Module: booth_mac_accumulator

---
 rtl/booth_mac_accumulator_pkg.sv | 24 ++
 rtl/booth_mac_accumulator_if.sv | 26 ++
 rtl/booth_mac_accumulator_booth_multiplier.sv | 37 +++
 rtl/booth_mac_accumulator.sv | 125 ++++++++++++
 tb/tb_booth_mac_accumulator.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/booth_mac_accumulator_pkg.sv
// Shared types and constants for the Booth multiply-accumulate dot-product engine.
// Saturation limits are returned as 32-bit patterns; callers truncate to their own width.
package booth_mac_accumulator_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } mac_state_e;

  localparam int TERM_W = 8;
  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  function automatic logic [31:0] satMaxBits(input int unsigned accW);
    return (32'h1 << (accW - 1)) - 32'h1;
  endfunction

  // The negative limit is the bitwise complement of the positive one.
  function automatic logic [31:0] satMinBits(input int unsigned accW);
    return ~satMaxBits(accW);
  endfunction

endpackage

// File: rtl/booth_mac_accumulator_if.sv
// Operand/result handshake bundle between a producer/consumer and the MAC engine.
interface booth_mac_accumulator_if #(
  parameter int ACC_W = 20
);

  logic                    clear;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [7:0]       in_a;
  logic signed [7:0]       in_b;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_acc;
  logic                    out_sat;

  modport master (
    output clear, in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_acc, out_sat
  );

  modport slave (
    input  clear, in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_acc, out_sat
  );

endinterface

// File: rtl/booth_mac_accumulator_booth_multiplier.sv
// Combinational 8x8 signed radix-4 Booth multiplier producing a 16-bit product.
module booth_multiplier
  import booth_mac_accumulator_pkg::*;
(
  input  logic signed [OP_W-1:0]   a_i,
  input  logic signed [OP_W-1:0]   b_i,
  output logic signed [PROD_W-1:0] product_o
);

  logic        [OP_W:0]     bExt;
  logic signed [PROD_W-1:0] aExt;

  // Each 3-bit window of the multiplier selects a digit in {-2,-1,0,1,2}.
  function automatic logic signed [PROD_W-1:0] partial(
    input logic [2:0]               grp,
    input logic signed [PROD_W-1:0] mcand
  );
    logic signed [PROD_W-1:0] pp;
    case (grp)
      3'b001, 3'b010: pp = mcand;
      3'b011:         pp = mcand <<< 1;
      3'b100:         pp = -(mcand <<< 1);
      3'b101, 3'b110: pp = -mcand;
      default:        pp = '0;
    endcase
    return pp;
  endfunction

  assign aExt = {{(PROD_W-OP_W){a_i[OP_W-1]}}, a_i};
  assign bExt = {b_i, 1'b0};

  assign product_o = partial(bExt[2:0], aExt)
                   + (partial(bExt[4:2], aExt) <<< 2)
                   + (partial(bExt[6:4], aExt) <<< 4)
                   + (partial(bExt[8:6], aExt) <<< 6);

endmodule

// File: rtl/booth_mac_accumulator.sv
// Saturating dot-product engine: accepts LEN operand pairs, accumulates their Booth
// products one cycle after acceptance, then holds the result until it is consumed.
module booth_mac_accumulator
  import booth_mac_accumulator_pkg::*;
#(
  parameter int LEN   = 4,
  parameter int ACC_W = 20
) (
  input logic                      clk,
  input logic                      rst,
  booth_mac_accumulator_if.slave   bus
);

  localparam logic [ACC_W-1:0]  SAT_MAX    = ACC_W'(satMaxBits(ACC_W));
  localparam logic [ACC_W-1:0]  SAT_MIN    = ACC_W'(satMinBits(ACC_W));
  localparam logic [TERM_W-1:0] LAST_TERM  = TERM_W'(LEN - 1);
  localparam logic [TERM_W-1:0] TERM_LIMIT = TERM_W'(LEN);

  mac_state_e               state_q, state_d;
  logic [TERM_W-1:0]        termCount_q, termCount_d;
  logic [ACC_W-1:0]         acc_q, acc_d;
  logic                     sat_q, sat_d;
  logic signed [OP_W-1:0]   opA_q, opA_d;
  logic signed [OP_W-1:0]   opB_q, opB_d;
  logic                     pipeValid_q, pipeValid_d;

  logic signed [PROD_W-1:0] product;
  logic [ACC_W:0]           sum;
  logic                     inXfer;
  logic                     outXfer;

  booth_multiplier uMult (
    .a_i       (opA_q),
    .b_i       (opB_q),
    .product_o (product)
  );

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_acc   = acc_q;
  assign bus.out_sat   = sat_q;

  assign inXfer  = bus.in_valid && bus.in_ready;
  assign outXfer = bus.out_valid && bus.out_ready;

  // One guard bit is enough: |acc| + |product| always fits in ACC_W+1 bits.
  assign sum = {acc_q[ACC_W-1], acc_q}
             + {{(ACC_W+1-PROD_W){product[PROD_W-1]}}, product};

  always_comb begin
    state_d     = state_q;
    termCount_d = termCount_q;
    acc_d       = acc_q;
    sat_d       = sat_q;
    opA_d       = opA_q;
    opB_d       = opB_q;
    pipeValid_d = 1'b0;

    if (pipeValid_q) begin
      if (sum[ACC_W] != sum[ACC_W-1]) begin
        acc_d = sum[ACC_W] ? SAT_MIN : SAT_MAX;
        sat_d = 1'b1;
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
    end

    if (inXfer) begin
      opA_d       = bus.in_a;
      opB_d       = bus.in_b;
      pipeValid_d = 1'b1;
      if (termCount_q != TERM_LIMIT) begin
        termCount_d = termCount_q + 1'b1;
      end
    end

    unique case (state_q)
      ACCUM: begin
        if (inXfer && (termCount_q == LAST_TERM)) begin
          state_d = FLUSH;
        end
      end
      FLUSH: state_d = DONE;
      DONE: begin
        if (outXfer) begin
          state_d     = ACCUM;
          acc_d       = '0;
          sat_d       = 1'b0;
          termCount_d = '0;
        end
      end
      default: state_d = ACCUM;
    endcase

    // Abort wins over everything except reset, including an operand arriving this cycle.
    if (bus.clear) begin
      state_d     = ACCUM;
      acc_d       = '0;
      sat_d       = 1'b0;
      termCount_d = '0;
      pipeValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      termCount_q <= '0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      opA_q       <= '0;
      opB_q       <= '0;
      pipeValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      termCount_q <= termCount_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      opA_q       <= opA_d;
      opB_q       <= opB_d;
      pipeValid_q <= pipeValid_d;
    end
  end

endmodule

// File: tb/tb_booth_mac_accumulator.sv
// Self-checking bench: per-cycle comparison against a transaction-level dot-product model,
// directed literal cases, long-length saturation instances and randomized traffic.
module tb_booth_mac_accumulator;

  localparam int LEN     = 4;
  localparam int ACC_W   = 17;
  localparam int ACC_MAX = (1 << (ACC_W - 1)) - 1;
  localparam int ACC_MIN = -(1 << (ACC_W - 1));

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  booth_mac_accumulator_if #(.ACC_W(ACC_W)) bus ();
  booth_mac_accumulator_if #(.ACC_W(20))    busLong ();
  booth_mac_accumulator_if #(.ACC_W(20))    busShort ();

  booth_mac_accumulator #(.LEN(LEN), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  booth_mac_accumulator #(.LEN(32), .ACC_W(20)) dutLong (
    .clk (clk),
    .rst (rst),
    .bus (busLong)
  );

  booth_mac_accumulator #(.LEN(31), .ACC_W(20)) dutShort (
    .clk (clk),
    .rst (rst),
    .bus (busShort)
  );

  int errors = 0;
  int checks = 0;
  bit checkEn = 1'b0;

  // Transaction-level reference: exact integer sum clamped after every product.
  int mAcc = 0;
  int mCount = 0;
  int mLatency = 0;
  bit mSat = 1'b0;
  bit mResultValid = 1'b0;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic modelFresh();
    mAcc = 0;
    mCount = 0;
    mLatency = 0;
    mSat = 1'b0;
    mResultValid = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (rst || bus.clear) begin
        modelFresh();
      end else if (mResultValid) begin
        if (bus.out_ready) modelFresh();
      end else if (mLatency > 0) begin
        mLatency--;
        if (mLatency == 0) mResultValid = 1'b1;
      end else if (bus.in_valid) begin
        mAcc = mAcc + int'(bus.in_a) * int'(bus.in_b);
        if (mAcc > ACC_MAX) begin
          mAcc = ACC_MAX;
          mSat = 1'b1;
        end else if (mAcc < ACC_MIN) begin
          mAcc = ACC_MIN;
          mSat = 1'b1;
        end
        mCount++;
        if (mCount == LEN) mLatency = 1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (checkEn) begin
        checkOutput("in_ready", longint'(bus.in_ready), longint'(!mResultValid && mLatency == 0));
        checkOutput("out_valid", longint'(bus.out_valid), longint'(mResultValid));
        if (mResultValid) begin
          checkOutput("out_acc", longint'(bus.out_acc), longint'(mAcc));
          checkOutput("out_sat", longint'(bus.out_sat), longint'(mSat));
        end
      end
    end
  end

  task automatic applyStimulus(input int a, input int b);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_a = 8'(a);
    bus.in_b = 8'(b);
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) checkOutput("accept_timeout", longint'(guard), 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic waitResult(output int latency);
    int cycles;
    cycles = 0;
    while (!bus.out_valid && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    if (cycles >= 100) checkOutput("result_timeout", longint'(cycles), 0);
    latency = cycles + 1;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  function automatic logic signed [7:0] randOp();
    case ($urandom_range(0, 7))
      0:       return 8'sh80;
      1:       return 8'sh7F;
      2:       return 8'shFF;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    int lat;
    int guard;
    logic signed [ACC_W-1:0] held;

    rst = 1'b1;
    bus.clear = 1'b0;      bus.in_valid = 1'b0;      bus.out_ready = 1'b0;
    bus.in_a = '0;         bus.in_b = '0;
    busLong.clear = 1'b0;  busLong.in_valid = 1'b0;  busLong.out_ready = 1'b0;
    busLong.in_a = '0;     busLong.in_b = '0;
    busShort.clear = 1'b0; busShort.in_valid = 1'b0; busShort.out_ready = 1'b0;
    busShort.in_a = '0;    busShort.in_b = '0;

    repeat (3) @(negedge clk);
    checkOutput("reset_out_valid", longint'(bus.out_valid), 0);
    checkOutput("reset_out_acc", longint'(bus.out_acc), 0);
    checkOutput("reset_out_sat", longint'(bus.out_sat), 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_in_ready", longint'(bus.in_ready), 1);
    checkEn = 1'b1;

    // Basic dot product and its result latency.
    applyStimulus(1, 5); applyStimulus(2, 6); applyStimulus(3, 7); applyStimulus(4, 8);
    waitResult(lat);
    checkOutput("dp_basic_latency", longint'(lat), 2);
    checkOutput("dp_basic_acc", longint'(bus.out_acc), 70);
    checkOutput("dp_basic_sat", longint'(bus.out_sat), 0);
    checkOutput("model_basic_acc", longint'(mAcc), 70);
    consume();

    // Extreme operands that cancel to a tiny sum.
    applyStimulus(-128, -128); applyStimulus(-128, 127); applyStimulus(127, -1); applyStimulus(0, 99);
    waitResult(lat);
    checkOutput("dp_extreme_acc", longint'(bus.out_acc), 1);
    checkOutput("model_extreme_acc", longint'(mAcc), 1);
    consume();

    // 4 * 16384 overflows a 17-bit accumulator by exactly one.
    repeat (4) applyStimulus(-128, -128);
    waitResult(lat);
    checkOutput("dp_sat_acc", longint'(bus.out_acc), 65535);
    checkOutput("dp_sat_flag", longint'(bus.out_sat), 1);
    checkOutput("model_sat_acc", longint'(mAcc), 65535);
    consume();

    // Held result under backpressure, with in_valid asserted throughout.
    repeat (4) applyStimulus(3, 3);
    waitResult(lat);
    held = bus.out_acc;
    bus.in_valid = 1'b1; bus.in_a = 8'sd7; bus.in_b = 8'sd7;
    repeat (5) begin
      @(negedge clk);
      checkOutput("stall_acc", longint'(bus.out_acc), 36);
      checkOutput("stall_acc_stable", longint'(bus.out_acc), longint'(held));
      checkOutput("stall_in_ready", longint'(bus.in_ready), 0);
    end
    consume();
    checkOutput("post_xfer_in_ready", longint'(bus.in_ready), 1);
    checkOutput("post_xfer_out_valid", longint'(bus.out_valid), 0);
    applyStimulus(7, 7); applyStimulus(1, 1); applyStimulus(1, 1); applyStimulus(1, 1);
    waitResult(lat);
    checkOutput("post_stall_acc", longint'(bus.out_acc), 52);
    consume();

    // Abort mid-product.
    applyStimulus(10, 10); applyStimulus(10, 10);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    repeat (4) applyStimulus(1, 1);
    waitResult(lat);
    checkOutput("clear_acc", longint'(bus.out_acc), 4);
    checkOutput("clear_sat", longint'(bus.out_sat), 0);
    consume();

    // Abort coinciding with an operand transfer drops that operand.
    bus.clear = 1'b1; bus.in_valid = 1'b1; bus.in_a = 8'sd50; bus.in_b = 8'sd50;
    @(negedge clk);
    bus.clear = 1'b0; bus.in_valid = 1'b0;
    repeat (4) applyStimulus(2, 3);
    waitResult(lat);
    checkOutput("clear_xfer_acc", longint'(bus.out_acc), 24);
    consume();

    // Reset while the last operand is still in flight.
    repeat (3) applyStimulus(1, 1);
    applyStimulus(9, 9);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_flush_out_valid", longint'(bus.out_valid), 0);
    checkOutput("rst_flush_out_acc", longint'(bus.out_acc), 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_flush_in_ready", longint'(bus.in_ready), 1);
    repeat (4) applyStimulus(1, 1);
    waitResult(lat);
    checkOutput("rst_flush_next_acc", longint'(bus.out_acc), 4);
    consume();

    // Long products at ACC_W=20: 32 terms clamp, 31 terms fit.
    busLong.in_valid = 1'b1;  busLong.in_a = 8'sh80;  busLong.in_b = 8'sh80;
    busShort.in_valid = 1'b1; busShort.in_a = 8'sh80; busShort.in_b = 8'sh80;
    guard = 0;
    while (!(busLong.out_valid && busShort.out_valid) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) checkOutput("long_timeout", longint'(guard), 0);
    checkOutput("len32_acc", longint'(busLong.out_acc), 524287);
    checkOutput("len32_sat", longint'(busLong.out_sat), 1);
    checkOutput("len31_acc", longint'(busShort.out_acc), 507904);
    checkOutput("len31_sat", longint'(busShort.out_sat), 0);
    busLong.in_valid = 1'b0;
    busShort.in_valid = 1'b0;

    // Randomized traffic with gaps, backpressure and occasional aborts.
    for (int i = 0; i < 1500; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_a      = randOp();
      bus.in_b      = randOp();
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.clear     = ($urandom_range(0, 59) == 0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.clear = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
